// File: rtl/fifo_display_scan.sv
// fifo_display_scan
// Shows the 8 FIFO slots on an 8-digit common-anode seven-segment display,
// one digit at a time. Each slot is read through the register file's second
// read port. Occupied slots show their hex value, empty slots stay blank, and
// the decimal point marks the head slot. Between digits there is a short
// period with all anodes off, so the previous digit does not ghost onto the
// next one.
module fifo_display_scan #(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,  // cycles each digit is driven
  parameter logic [7:0]  BLANK_CYC = 8'd16       // all-off cycles between digits
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] valid,
  input  logic [2:0] head,
  input  logic [3:0] rd1,
  output logic [2:0] ra1,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DISP  = 1'b1
  } state_t;

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [2:0]  idx_r;
  logic [7:0]  an_r;
  logic [6:0]  seg_r;
  logic        dp_r;

  logic        blank_last_s;
  logic        disp_last_s;
  logic [7:0]  an_next_s;
  logic [6:0]  seg_next_s;
  logic        dp_next_s;

  // Hex digit to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'h40;
      4'h1:    p = 7'h79;
      4'h2:    p = 7'h24;
      4'h3:    p = 7'h30;
      4'h4:    p = 7'h19;
      4'h5:    p = 7'h12;
      4'h6:    p = 7'h02;
      4'h7:    p = 7'h78;
      4'h8:    p = 7'h00;
      4'h9:    p = 7'h10;
      4'hA:    p = 7'h08;
      4'hB:    p = 7'h03;
      4'hC:    p = 7'h46;
      4'hD:    p = 7'h21;
      4'hE:    p = 7'h06;
      4'hF:    p = 7'h0E;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  assign blank_last_s = (cnt_r == {8'd0, BLANK_CYC - 8'd1});
  assign disp_last_s  = (cnt_r == (SCAN_DIV - 16'd1));

  // Digit pattern captured when the current slot is switched on.
  always_comb begin
    an_next_s  = ~(8'b0000_0001 << idx_r);
    seg_next_s = 7'h7F;
    dp_next_s  = 1'b1;
    if (valid[idx_r]) begin
      seg_next_s = hex7(rd1);
      dp_next_s  = ~(head == idx_r);
    end else begin
      seg_next_s = 7'h7F;
      dp_next_s  = 1'b1;
    end
  end

  // Blank/display scan sequencer; the outputs are loaded only on phase changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_BLANK;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      an_r    <= 8'hFF;
      seg_r   <= 7'h7F;
      dp_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_BLANK: begin
          if (blank_last_s) begin
            an_r    <= an_next_s;
            seg_r   <= seg_next_s;
            dp_r    <= dp_next_s;
            cnt_r   <= 16'd0;
            state_r <= ST_DISP;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
          end
        end
        ST_DISP: begin
          if (disp_last_s) begin
            an_r    <= 8'hFF;
            seg_r   <= 7'h7F;
            dp_r    <= 1'b1;
            idx_r   <= idx_r + 3'd1;
            cnt_r   <= 16'd0;
            state_r <= ST_BLANK;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_BLANK;
          cnt_r   <= 16'd0;
          an_r    <= 8'hFF;
          seg_r   <= 7'h7F;
          dp_r    <= 1'b1;
        end
      endcase
    end
  end

  assign ra1 = idx_r;
  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_fifo_display_scan.sv
// Directed bench for fifo_display_scan with SCAN_DIV=4 and BLANK_CYC=2.
// A small register-file model drives rd1 from mem[ra1].
module tb_fifo_display_scan;

  logic       clk;
  logic       rst;
  logic [7:0] valid;
  logic [2:0] head;
  logic [3:0] rd1;
  logic [2:0] ra1;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  logic [3:0] mem [8];
  logic [6:0] hex_tab [16];

  int pass_cnt;
  int total_cnt;

  fifo_display_scan #(.SCAN_DIV(16'd4), .BLANK_CYC(8'd2)) dut (
    .clk(clk), .rst(rst), .valid(valid), .head(head),
    .rd1(rd1), .ra1(ra1), .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file read port model.
  always_comb rd1 = mem[ra1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then sample 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse reset, release it on a falling edge, and stop just after digit 0 lights.
  task automatic restart();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    step(2);
  endtask

  // Walk one frame starting just after digit 0 lights. Check every lit digit
  // and the blank gap after it.
  task automatic scan_frame(input string tag);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      e_an  = ~(8'b0000_0001 << k);
      e_seg = valid[k] ? hex_tab[mem[k]] : 7'h7F;
      e_dp  = ~(valid[k] && (head == k[2:0]));
      check($sformatf("%s an d%0d", tag, k), an, e_an);
      check($sformatf("%s seg d%0d", tag, k), seg, e_seg);
      check($sformatf("%s dp d%0d", tag, k), dp, e_dp);
      check($sformatf("%s ra1 d%0d", tag, k), ra1, k);
      step(4);
      check($sformatf("%s blank d%0d", tag, k), an, 8'hFF);
      step(2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    pass_cnt  = 0;
    total_cnt = 0;
    rst   = 1'b1;
    valid = 8'hFF;
    head  = 3'd0;
    for (int k = 0; k < 8; k++) mem[k] = k[3:0];

    // 1: reset state while clock runs
    #1 rst = 1'b0;
    step(3);
    check("rst an", an, 8'hFF);
    check("rst seg", seg, 7'h7F);
    check("rst dp", dp, 1'b1);
    check("rst ra1", ra1, 3'd0);

    // 2: scan order with hand timing, then a full-frame walk and wrap
    @(negedge clk) rst = 1'b1;
    step(1);
    check("c1 an", an, 8'hFF);
    step(1);
    check("c2 an", an, 8'hFE);
    check("c2 seg", seg, 7'h40);
    check("c2 dp", dp, 1'b0);
    step(3);
    check("c5 an", an, 8'hFE);
    step(1);
    check("c6 an", an, 8'hFF);
    step(2);
    check("c8 an", an, 8'hFD);
    check("c8 seg", seg, 7'h79);
    check("c8 dp", dp, 1'b1);
    restart();
    scan_frame("order");
    check("wrap an", an, 8'hFE);
    check("wrap seg", seg, 7'h40);

    // 1b: asynchronous reset in the middle of a lit digit
    step(1);
    rst = 1'b0;
    #1;
    check("async an", an, 8'hFF);
    check("async seg", seg, 7'h7F);
    check("async dp", dp, 1'b1);
    check("async ra1", ra1, 3'd0);

    // 3: blanking of empty slots, and an empty FIFO
    for (int k = 0; k < 8; k++) mem[k] = 4'hA;
    valid = 8'b0000_0101;
    restart();
    scan_frame("blank");
    valid = 8'h00;
    restart();
    scan_frame("empty");

    // 4: head marker positions
    for (int k = 0; k < 8; k++) mem[k] = k[3:0];
    valid = 8'hFF;
    head  = 3'd5;
    restart();
    scan_frame("head5");
    head = 3'd7;
    restart();
    scan_frame("head7");
    valid = 8'b1111_0111;
    head  = 3'd3;
    restart();
    scan_frame("head3e");

    // 5: snapshot, a mid-digit data change shows only on the next visit
    valid = 8'hFF;
    head  = 3'd0;
    restart();
    step(6);
    check("snap lit", seg, 7'h79);
    step(1);
    mem[1] = 4'hE;
    step(1);
    check("snap hold", seg, 7'h79);
    step(1);
    check("snap hold2", seg, 7'h79);
    step(1);
    check("snap off", an, 8'hFF);
    step(44);
    check("snap an", an, 8'hFD);
    check("snap new", seg, 7'h06);

    // 6: hex table sweep on digit 0
    valid = 8'h01;
    head  = 3'd1;
    for (int v = 0; v < 16; v++) begin
      mem[0] = v[3:0];
      restart();
      check($sformatf("hex %0h", v), seg, hex_tab[v]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
